// File: rtl/fb_draw_sched_pkg.sv
// fb_pkg: shared constants and types for the framebuffer write scheduler.
//   FB_W/FB_H   : framebuffer geometry (1 bit per pixel)
//   SPR         : sprite edge length (square, power of two)
//   XW/YW       : write-port address widths
//   SPR_*       : sprite kind encodings
//   state_e     : scheduler FSM states
package fb_pkg;

    localparam int FB_W   = 320;
    localparam int FB_H   = 200;
    localparam int SPR    = 16;
    localparam int SPR_CW = $clog2(SPR);
    localparam int XW     = 9;
    localparam int YW     = 8;

    localparam logic [1:0] SPR_BIG   = 2'd0;
    localparam logic [1:0] SPR_MID   = 2'd1;
    localparam logic [1:0] SPR_SMALL = 2'd2;
    localparam logic [1:0] SPR_ERASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        BLIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fb_draw_sched_if.sv
// fb_draw_sched_if: requester + framebuffer write-port signals of the scheduler.
//   master : the game logic / write port side (drives requests, window)
//   slave  : the scheduler (drives acks, busy and the write port)
interface fb_draw_sched_if;
    import fb_pkg::*;

    logic          wr_window;
    logic          clr_req;
    logic          clr_ack;
    logic          spr_req;
    logic [XW-1:0] spr_x;
    logic [YW-1:0] spr_y;
    logic [1:0]    spr_kind;
    logic          spr_ack;
    logic          busy;
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic          wr_data;

    modport master (
        output wr_window, clr_req, spr_req, spr_x, spr_y, spr_kind,
        input  clr_ack, spr_ack, busy, wr_en, wr_x, wr_y, wr_data
    );

    modport slave (
        input  wr_window, clr_req, spr_req, spr_x, spr_y, spr_kind,
        output clr_ack, spr_ack, busy, wr_en, wr_x, wr_y, wr_data
    );

endinterface

// File: rtl/fb_draw_sched_sprite_shape.sv
// sprite_shape: combinational sprite art lookup.
//   kind_i : sprite kind (SPR_BIG/MID/SMALL/ERASE)
//   dx_i   : column inside the sprite
//   dy_i   : row inside the sprite
//   pix_o  : pixel value (every sprite pixel is opaque, zeros included)
// Upper half is empty; lower half is a solid bar whose width depends on kind.
module sprite_shape
    import fb_pkg::*;
#(
    parameter int CW = SPR_CW
) (
    input  logic [1:0]    kind_i,
    input  logic [CW-1:0] dx_i,
    input  logic [CW-1:0] dy_i,
    output logic          pix_o
);

    always_comb begin
        pix_o = 1'b0;
        if (dy_i >= CW'(8)) begin
            case (kind_i)
                SPR_BIG:   pix_o = (dx_i < CW'(12));
                SPR_MID:   pix_o = (dx_i < CW'(11));
                SPR_SMALL: pix_o = (dx_i < CW'(8));
                default:   pix_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fb_draw_sched.sv
// fb_draw_sched: framebuffer write-port scheduler.
//   clk, rst   : clock, synchronous active-high reset
//   bus.slave  : clear / sprite request-ack pairs, wr_window, busy and the
//                registered framebuffer write port (wr_en, wr_x, wr_y, wr_data)
// A granted clear writes every pixel to 0 in x-major order; a granted blit
// walks an SPR x SPR box from the latched origin, clipping off-screen pixels.
// Both pause (counters hold, no write) whenever wr_window is low.
module fb_draw_sched #(
    parameter int FB_W = fb_pkg::FB_W,
    parameter int FB_H = fb_pkg::FB_H,
    parameter int SPR  = fb_pkg::SPR
) (
    input  logic           clk,
    input  logic           rst,
    fb_draw_sched_if.slave bus
);
    import fb_pkg::*;

    localparam int CW = $clog2(SPR);

    state_e        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [1:0]    kind_q, kind_d;
    logic          op_clr_q, op_clr_d;

    logic          wr_en_q, wr_en_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic          wr_data_q, wr_data_d;
    logic          clr_ack_q, clr_ack_d;
    logic          spr_ack_q, spr_ack_d;
    logic          busy_q, busy_d;

    // Blit target at one extra bit so off-screen pixels are detected, never wrapped.
    logic [XW:0]   bx;
    logic [YW:0]   by;
    logic          clip;
    logic          shape_pix;

    assign bx   = {1'b0, ox_q} + (XW+1)'(cx_q);
    assign by   = {1'b0, oy_q} + (YW+1)'(cy_q);
    assign clip = (bx >= (XW+1)'(FB_W)) || (by >= (YW+1)'(FB_H));

    sprite_shape #(.CW(CW)) u_shape (
        .kind_i (kind_q),
        .dx_i   (cx_q[CW-1:0]),
        .dy_i   (cy_q[CW-1:0]),
        .pix_o  (shape_pix)
    );

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        kind_d    = kind_q;
        op_clr_d  = op_clr_q;
        wr_en_d   = 1'b0;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;
        clr_ack_d = 1'b0;
        spr_ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The ack is visible while already back in IDLE; the requester
                // still holds req during that cycle, so no grant then.
                if (bus.wr_window && !(clr_ack_q || spr_ack_q)) begin
                    if (bus.clr_req || bus.spr_req) begin
                        state_d  = bus.clr_req ? CLEAR : BLIT;
                        op_clr_d = bus.clr_req;
                        cx_d     = '0;
                        cy_d     = '0;
                        ox_d     = bus.spr_x;
                        oy_d     = bus.spr_y;
                        kind_d   = bus.spr_kind;
                    end
                end
            end

            CLEAR: begin
                if (bus.wr_window) begin
                    wr_en_d   = 1'b1;
                    wr_x_d    = cx_q;
                    wr_y_d    = cy_q;
                    wr_data_d = 1'b0;
                    if (cx_q == XW'(FB_W - 1)) begin
                        cx_d = '0;
                        if (cy_q == YW'(FB_H - 1)) state_d = DONE;
                        else                       cy_d    = cy_q + YW'(1);
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end
            end

            BLIT: begin
                if (bus.wr_window) begin
                    // Clipped pixels still consume a cycle so blit timing is fixed.
                    wr_en_d = !clip;
                    if (!clip) begin
                        wr_x_d    = bx[XW-1:0];
                        wr_y_d    = by[YW-1:0];
                        wr_data_d = shape_pix;
                    end
                    if (cx_q == XW'(SPR - 1)) begin
                        cx_d = '0;
                        if (cy_q == YW'(SPR - 1)) state_d = DONE;
                        else                      cy_d    = cy_q + YW'(1);
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end
            end

            DONE: begin
                clr_ack_d = op_clr_q;
                spr_ack_d = !op_clr_q;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            kind_q    <= '0;
            op_clr_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= 1'b0;
            clr_ack_q <= 1'b0;
            spr_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            kind_q    <= kind_d;
            op_clr_q  <= op_clr_d;
            wr_en_q   <= wr_en_d;
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_data_q <= wr_data_d;
            clr_ack_q <= clr_ack_d;
            spr_ack_q <= spr_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_x    = wr_x_q;
    assign bus.wr_y    = wr_y_q;
    assign bus.wr_data = wr_data_q;
    assign bus.clr_ack = clr_ack_q;
    assign bus.spr_ack = spr_ack_q;
    assign bus.busy    = busy_q;

endmodule
